// File: rtl/dma_wb.sv
// dma_wb: word-copy DMA with a Wishbone slave register window and a Wishbone
// master port that copies SRC->DST one word at a time, with a DONE interrupt.
// Ports:
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   wb_*_i / wb_*_o    : slave register window (SRC, DST, LEN, CTRL/STAT)
//   wbm_*_o / wbm_*_i  : bus master used for the copy
//   irq_o              : DONE & IRQ_EN
module dma_wb #(
  parameter int LEN_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [25:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        irq_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RGAP = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [31:0]         buf_q, buf_d;
  logic [31:0]         rdat_q, rdat_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                abort_q, abort_d;
  logic                ack_q, ack_d;

  logic        req, wr, busy;
  logic        ctrl_wr, start_wr, abort_wr, abort_now;
  logic        hw_done, hw_abort;
  logic        wr_src, wr_dst, wr_len;
  logic [1:0]  idx;
  logic [31:0] wmask, rdata;
  logic [15:0] rem16;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[25:2];

  always_comb begin
    idx      = wb_adr_i[1:0];
    req      = wb_stb_i & wb_cyc_i & ~ack_q;
    wr       = req & wb_we_i;
    busy     = (state_q != S_IDLE);
    wmask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    ctrl_wr  = wr & (idx == 2'd3);
    start_wr = ctrl_wr & wb_sel_i[0] & wb_dat_i[0];
    abort_wr = ctrl_wr & wb_sel_i[0] & wb_dat_i[2];
    // An abort written in the same cycle as an ack takes effect at once.
    abort_now = abort_q | (abort_wr & busy);
    wr_src   = wr & ~busy & (idx == 2'd0);
    wr_dst   = wr & ~busy & (idx == 2'd1);
    wr_len   = wr & ~busy & (idx == 2'd2);
    rem16    = 16'(rem_q);
  end

  always_comb begin
    rdata = 32'd0;
    unique case (idx)
      2'd0: rdata = src_q;
      2'd1: rdata = dst_q;
      2'd2: rdata = 32'(len_q);
      2'd3: rdata = {rem16, 6'd0, aborted_q, done_q,
                     6'd0, irq_en_q, busy};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    buf_d     = buf_q;
    len_d     = len_q;
    rem_d     = rem_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    abort_d   = abort_q;
    ack_d     = req;
    rdat_d    = rdat_q;
    hw_done   = 1'b0;
    hw_abort  = 1'b0;

    if (req & ~wb_we_i) rdat_d = rdata;

    unique case (1'b1)
      wr_src: src_d = ((src_q & ~wmask) | (wb_dat_i & wmask))
                      & 32'hffff_fffc;
      wr_dst: dst_d = ((dst_q & ~wmask) | (wb_dat_i & wmask))
                      & 32'hffff_fffc;
      wr_len: len_d = LEN_BITS'((32'(len_q) & ~wmask)
                      | (wb_dat_i & wmask));
      default: ;
    endcase

    if (ctrl_wr & wb_sel_i[0]) irq_en_d = wb_dat_i[1];
    if (abort_wr & busy) abort_d = 1'b1;

    if (ctrl_wr & wb_sel_i[1]) begin
      if (wb_dat_i[8]) done_d = 1'b0;
      if (wb_dat_i[9]) aborted_d = 1'b0;
    end

    if (start_wr & ~abort_wr & ~busy) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
      rem_d     = len_q;
      if (len_q == '0) hw_done = 1'b1;
      else state_d = S_RD;
    end

    unique case (state_q)
      S_RD: if (wbm_ack_i) begin
        buf_d = wbm_dat_i;
        if (abort_now) begin
          state_d  = S_IDLE;
          hw_abort = 1'b1;
        end else begin
          state_d = S_RGAP;
        end
      end
      S_RGAP: begin
        if (abort_now) begin
          state_d  = S_IDLE;
          hw_abort = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: if (wbm_ack_i) begin
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        rem_d = rem_q - LEN_BITS'(1);
        if (abort_now) begin
          state_d  = S_IDLE;
          hw_abort = 1'b1;
        end else begin
          state_d = S_WGAP;
        end
      end
      S_WGAP: begin
        if (abort_now) begin
          state_d  = S_IDLE;
          hw_abort = 1'b1;
        end else if (rem_q == '0) begin
          state_d = S_IDLE;
          hw_done = 1'b1;
        end else begin
          state_d = S_RD;
        end
      end
      default: ;
    endcase

    // Hardware set beats a same-cycle W1C clear.
    if (hw_done) done_d = 1'b1;
    if (hw_abort) aborted_d = 1'b1;
    if (state_d == S_IDLE) abort_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      buf_q     <= '0;
      rdat_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      buf_q     <= buf_d;
      rdat_q    <= rdat_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      ack_q     <= ack_d;
    end
  end

  // Master outputs decode straight from the state flop so reset drops them
  // without waiting for a clock edge.
  always_comb begin
    wbm_cyc_o = (state_q == S_RD) | (state_q == S_WR);
    wbm_stb_o = wbm_cyc_o;
    wbm_we_o  = (state_q == S_WR);
    wbm_sel_o = wbm_cyc_o ? 4'hf : 4'h0;
    wbm_adr_o = 32'd0;
    wbm_dat_o = 32'd0;
    if (state_q == S_RD) wbm_adr_o = src_q;
    if (state_q == S_WR) begin
      wbm_adr_o = dst_q;
      wbm_dat_o = buf_q;
    end
    wb_ack_o = ack_q;
    wb_dat_o = rdat_q;
    irq_o    = done_q & irq_en_q;
  end

endmodule

// File: doc/dma_wb.md
# dma_wb

Word-copy DMA engine for the Zeitlos SOC. Software programs source, destination and length through a Wishbone slave register window. The block then copies 32-bit words memory-to-memory through its own Wishbone master port. That port feeds the system Wishbone arbiter alongside the CPU master, and the block raises a level interrupt toward `cpu_irq` on completion.

## Interface
Parameters:
- `LEN_BITS`, default 16: width of the word-count register (max transfer 2^LEN_BITS−1 words).

Ports:
- `wb_clk_i`  in  1  system clock; all logic on its rising edge.
- `wb_rst_i`  in  1  asynchronous reset, active-high.
- `wb_adr_i`  in  26  slave word address; only [1:0] decoded.
- `wb_dat_i`  in  32  slave write data.
- `wb_dat_o`  out  32  slave read data.
- `wb_we_i`  in  1  slave write enable.
- `wb_sel_i`  in  4  slave byte enables.
- `wb_stb_i`, `wb_cyc_i`  in  1  slave strobe and cycle.
- `wb_ack_o`  out  1  slave acknowledge.
- `wbm_adr_o`  out  32  master byte address.
- `wbm_dat_o`  out  32  master write data.
- `wbm_dat_i`  in  32  master read data.
- `wbm_we_o`  out  1  master write enable.
- `wbm_sel_o`  out  4  master byte enables; always 4'hf during a cycle.
- `wbm_stb_o`, `wbm_cyc_o`  out  1  master strobe and cycle.
- `wbm_ack_i`  in  1  master acknowledge.
- `irq_o`  out  1  interrupt: DONE & IRQ_EN.

## Operation
Registers by word index, with per-byte `wb_sel_i` honoured on writes:
- 0 SRC: source byte address; bits[1:0] forced 0.
- 1 DST: destination byte address; bits[1:0] forced 0.
- 2 LEN: word count, zero-extended on read.
- 3 CTRL/STAT:
  - Write bits (byte lane 0): bit0 START (self-clearing), bit1 IRQ_EN, bit2 ABORT.
  - Write bits (byte lane 1): bit8 W1C DONE, bit9 W1C ABORTED.
  - Read: bit0 BUSY, bit1 IRQ_EN, bit8 DONE, bit9 ABORTED, [31:16] remaining count.

Register rules:
- Writes to SRC, DST and LEN while BUSY are ignored but still acked. SRC and DST read back the live, incrementing pointers.
- START while idle copies LEN into the remaining counter, clears DONE and ABORTED, and enters RD. START while BUSY is ignored.
- LEN=0 with START sets DONE on the next cycle, issues no bus cycles, and BUSY never asserts.

Master FSM states IDLE, RD, RGAP, WR, WGAP:
- IDLE: master outputs low.
- RD: `cyc=stb=1`, `we=0`, `adr=SRC`. On `wbm_ack_i`, latch `wbm_dat_i` into the buffer and go to RGAP.
- RGAP: one cycle with cyc/stb low, then WR.
- WR: `cyc=stb=1`, `we=1`, `adr=DST`, `dat_o=buffer`. On ack: SRC+=4, DST+=4, remaining−=1, go to WGAP.
- WGAP: one cycle low. Go to IDLE and set DONE if remaining==0; otherwise go to RD.
- Pointers wrap modulo 2^32.

ABORT handling:
- ABORT while BUSY: the outstanding phase completes normally (wait for ack). The FSM then goes to IDLE with ABORTED=1 and DONE unchanged. Remaining holds the count of uncopied words; a write that completed is counted.
- START and ABORT in the same write: ABORT wins, so no transfer starts when idle.
- A hardware DONE/ABORTED set in the same cycle as a W1C write: set wins.

BUSY is 1 in every state except IDLE.

## Timing
- Slave: `wb_ack_o` is registered and pulses exactly one cycle, in the cycle after `wb_stb_i & wb_cyc_i & !wb_ack_o`. Zero added wait states. Read data is valid with ack. Register writes take effect at the ack edge.
- Master: stb is held until ack is sampled high. Against a 1-wait slave (ack the cycle after stb), each phase takes 3 cycles (stb, ack, gap), so one word takes 6 cycles.
- DONE rises at the edge ending the final WGAP. `irq_o` follows combinationally from the DONE/IRQ_EN registers.
- Reset (async, any time): all master outputs, `wb_ack_o`, `irq_o` and `wb_dat_o` go to 0 immediately, including a bus cycle that is mid-phase. All registers reset to 0 and the FSM goes to IDLE.

## Test plan
- Basic copy: BRAM model seeded 0x100..0x10C = 1,2,3,4. SRC=0x100, DST=0x200, LEN=4, CTRL=0x3. Required: 0x200..0x20C = 1,2,3,4; DONE=1; irq_o=1; final SRC=0x110, DST=0x210; 24 cycles from first stb to DONE.
- Zero length: LEN=0, START. Required: no `wbm_cyc_o` activity, DONE=1 one cycle after ack, and BUSY never read 1.
- Abort: LEN=100, ABORT issued during the 3rd word's RD phase. Required: that word's read completes, no further WR, ABORTED=1, DONE=0, remaining=98.
- Busy protection and W1C: write LEN=7 and START during a transfer. Required: both ignored, the copy length is unchanged, and the `wb_ack_o` pulse is still one cycle. Then write CTRL=0x100. Required: DONE=0, irq_o=0.
- Pointer wrap and slow slave: SRC=0xFFFF_FFFC, LEN=2, with a slave acking after 5 waits. Required: second read at 0x0000_0000, stb held steady until ack, data intact.
- Async reset mid-WR. Required: `wbm_cyc_o`/`wbm_stb_o` drop without waiting for a clock edge, and all registers read 0 after reset.
